// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential 4x4 shift-and-add multiplier:
// operand width, iteration count, counter width and FSM state encoding.
package mult_seq_pkg;

  localparam int N_BITS = 4;
  localparam int N_ITER = 4;
  localparam int CNT_W  = 3;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/multiplicador_seq_4bits_if.sv
// Start/busy/done handshake bundle between the ALU decoder (master)
// and the sequential multiplier (slave).
interface multiplicador_seq_4bits_if
  import mult_seq_pkg::*;
  ();

  logic                  start;
  logic [N_BITS-1:0]     a;
  logic [N_BITS-1:0]     b;
  logic                  busy;
  logic                  done;
  logic [2*N_BITS-1:0]   p;

  modport master (
    output start, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, a, b,
    output busy, done, p
  );

endinterface

// File: rtl/somador_4bits.sv
// 4-bit unsigned ripple adder with carry in/out, shared by the
// multiplier across all of its iterations.
module somador_4bits
  import mult_seq_pkg::*;
  (
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  input  logic              cin,
  output logic [N_BITS-1:0] s,
  output logic              cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N_BITS{1'b0}}, cin};

endmodule

// File: rtl/multiplicador_seq_4bits.sv
// Sequential 4x4 unsigned shift-and-add multiplier controller.
// One somador_4bits is reused for four iterations; the product {ACC,Q}
// is published on the one-cycle done pulse and held until the next start.
// Optional build macro MULT_SEQ_ZERO_SKIP_EN: a zero operand jumps
// straight from IDLE to DONE with p=0 (latency 1).
// The adder carry lands directly in ACC[3] through the shift, so no
// separate carry flop is kept: it would always read back as zero.
module multiplicador_seq_4bits
  import mult_seq_pkg::*;
  (
  input  logic                      clk,
  input  logic                      rst_n,
  multiplicador_seq_4bits_if.slave  bus
);

  state_t            state;
  state_t            state_nxt;
  logic [N_BITS-1:0] m;
  logic [N_BITS-1:0] acc;
  logic [N_BITS-1:0] q;
  logic [CNT_W-1:0]  cnt;
  logic [2*N_BITS-1:0] p_r;
  logic              busy_r;
  logic              done_r;

  logic [N_BITS-1:0] add_b;
  logic [N_BITS-1:0] sum;
  logic              cout;
  logic              last_iter;

  assign add_b     = q[0] ? m : '0;
  assign last_iter = (cnt == CNT_W'(N_ITER - 1));

  somador_4bits u_somador (
    .a    (acc),
    .b    (add_b),
    .cin  (1'b0),
    .s    (sum),
    .cout (cout)
  );

`ifdef MULT_SEQ_ZERO_SKIP_EN
  logic zero_op;
  assign zero_op = (bus.a == '0) || (bus.b == '0);
`endif

  // Next-state decode; start is only honoured in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
`ifdef MULT_SEQ_ZERO_SKIP_EN
          state_nxt = zero_op ? S_DONE : S_CALC;
`else
          state_nxt = S_CALC;
`endif
        end
      end
      S_CALC:  if (last_iter) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State plus busy/done flops, loaded from the next state so both are glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_r <= (state_nxt != S_IDLE);
      done_r <= (state_nxt == S_DONE);
    end
  end

  // Operand capture, shift-and-add iteration and product publish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m   <= '0;
      acc <= '0;
      q   <= '0;
      cnt <= '0;
      p_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            m   <= bus.a;
            q   <= bus.b;
            acc <= '0;
            cnt <= '0;
            p_r <= '0;
          end
        end
        S_CALC: begin
          {acc, q} <= {cout, sum, q[N_BITS-1:1]};
          cnt      <= cnt + 1'b1;
          if (last_iter) p_r <= {cout, sum, q[N_BITS-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.p    = p_r;

endmodule

// File: tb/tb_multiplicador_seq_4bits.sv
// Self-checking bench for multiplicador_seq_4bits: directed scenarios with
// literal expectations plus randomized traffic checked every cycle against
// a cycle-count/product model built from a*b and the accept latency.
module tb_multiplicador_seq_4bits;

  logic clk;
  logic rst_n;

  multiplicador_seq_4bits_if bus ();

  multiplicador_seq_4bits dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [3:0] a, input logic [3:0] b);
`ifdef MULT_SEQ_ZERO_SKIP_EN
    if (a == 4'd0 || b == 4'd0) return 1;
`endif
    return 5;
  endfunction

  // Reference model: t = cycles since acceptance (-1 when idle)
  int         t;
  int         lat;
  logic [7:0] prod;
  logic [7:0] exp_p;
  logic       exp_busy;
  logic       exp_done;

  assign exp_busy = (t >= 1);
  assign exp_done = (t >= 1) && (t == lat);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t     <= -1;
      lat   <= 5;
      prod  <= 8'h00;
      exp_p <= 8'h00;
    end else if (t < 0) begin
      if (bus.start === 1'b1) begin
        prod <= {4'b0, bus.a} * {4'b0, bus.b};
        lat  <= lat_of(bus.a, bus.b);
        t    <= 1;
        if (lat_of(bus.a, bus.b) == 1) exp_p <= 8'h00;
        else                           exp_p <= 8'h00;
      end
    end else if (t == lat) begin
      t <= -1;
    end else begin
      t <= t + 1;
      if (t + 1 == lat) exp_p <= prod;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy_model", bus.busy, exp_busy);
      check("done_model", bus.done, exp_done);
      check("p_model", bus.p, exp_p);
    end
  end

  task automatic op(input logic [3:0] ai, input logic [3:0] bi,
                    input logic [7:0] pe, input int le, input string nm);
    int k;
    @(negedge clk);
    bus.start = 1'b1; bus.a = ai; bus.b = bi;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    while (bus.done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_latency"}, k, le);
    check({nm, "_p"}, bus.p, pe);
  endtask

  initial begin
    int dones;
    bus.start = 1'b0; bus.a = 4'd0; bus.b = 4'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_p", bus.p, 8'h00);
    cmp_en = 1'b1;
    rst_n = 1'b1;

    // 3 x 5, product must persist while idle
    op(4'd3, 4'd5, 8'h0F, 5, "mul_3x5");
    repeat (10) @(negedge clk);
    check("hold_p_3x5", bus.p, 8'h0F);
    check("hold_busy", bus.busy, 1'b0);

    op(4'd15, 4'd15, 8'hE1, 5, "mul_15x15");
`ifdef MULT_SEQ_ZERO_SKIP_EN
    op(4'd0, 4'd9, 8'h00, 1, "mul_0x9");
`else
    op(4'd0, 4'd9, 8'h00, 5, "mul_0x9");
`endif
    op(4'd13, 4'd11, 8'h8F, 5, "mul_13x11");

    // 7 x 6 with stray start pulses in CALC and DONE
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd7; bus.b = 4'd6;
    dones = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dones++;
        check("ignore_done_cycle", c, 5);
        check("ignore_p", bus.p, 8'h2A);
      end
      bus.start = (c == 2 || c == 5);
      if (c == 2) begin bus.a = 4'd1; bus.b = 4'd1; end
    end
    bus.start = 1'b0;
    check("ignore_done_count", dones, 1);

    // Asynchronous reset in cycle 3 of 9 x 9
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd9; bus.b = 4'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", bus.busy, 1'b0);
    check("async_rst_done", bus.done, 1'b0);
    check("async_rst_p", bus.p, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("no_done_after_rst", dones, 0);
    op(4'd2, 4'd8, 8'h10, 5, "mul_2x8");

    // start held high: done at cycles 5, 11, 17
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd4; bus.b = 4'd4;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      check("held_done", bus.done, (c % 6) == 5);
      if (c % 6 == 5) check("held_p", bus.p, 8'h10);
    end
    bus.start = 1'b0;
    repeat (8) @(negedge clk);

    // Randomized traffic, checked by the per-cycle model comparison
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.a = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
      bus.b = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
    end
    bus.start = 1'b0;
    repeat (8) @(negedge clk);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
